// File: rtl/fifo_pkg.sv
// Shared constants and pointer helpers for the async FIFO read side.
package fifo_pkg;

  localparam int unsigned DefDataSize = 8;
  localparam int unsigned DefAddrSize = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/rd_ptr_empty.sv
// Read pointer (binary + Gray) and registered empty flag for the read clock domain.
module rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = DefAddrSize
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty
);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rgray_d;
  logic              rempty_q;

  // Increment is gated by the registered empty flag so rbin never passes the write pointer.
  always_comb begin
    rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, (rinc & ~rempty_q)};
    rgray_d = (ADDRSIZE + 1)'(bin2gray(32'(rbin_d)));
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      rempty_q <= (rgray_d == rq2_wptr);
    end
  end

  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read side with a 2-entry output skid buffer giving a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DefDataSize,
  parameter int unsigned ADDRSIZE = DefAddrSize
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [DATASIZE-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                fetch, pop;

  // Two entries let a fetch proceed without looking at out_ready.
  assign fetch = !rempty && (cnt_q < 2'd2);
  assign pop   = (cnt_q != 2'd0) && out_ready;

  rd_ptr_empty #(
    .ADDRSIZE(ADDRSIZE)
  ) u_rd_ptr_empty (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rinc     (fetch),
    .rq2_wptr (rq2_wptr),
    .raddr    (raddr),
    .rptr     (rptr),
    .rempty   (rempty)
  );

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    unique case ({fetch, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = rdata;
        else               buf1_d = rdata;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data  = buf0_q;
  assign out_valid = (cnt_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural memory/write-side model.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   rq2_wptr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  logic [DW-1:0] mem [1 << AW];
  logic [AW:0]   wbin;
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_wr;

  fifo_rd_stream #(
    .DATASIZE(DW),
    .ADDRSIZE(AW)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rdata     (rdata),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 rclk = ~rclk;
  assign rdata = mem[raddr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Write side: store the word, publish the Gray write pointer, record expectation.
  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 1'b1;
    rq2_wptr = wbin ^ (wbin >> 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge rclk); #1;
    rrst_n = 1'b0;
    exp_q.delete();
    wbin = '0;
    rq2_wptr = '0;
    repeat (n) @(posedge rclk);
    #1 rrst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge rclk);
      k++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops on each handshake, and checks hold-under-backpressure.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("order", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    wbin = '0;
    rrst_n = 1'b0;
    out_ready = 1'b0;
    rq2_wptr = 5'b00011;
    repeat (2) @(posedge rclk);
    #1;
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rptr", 32'(rptr), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rq2_wptr = '0;
    rrst_n = 1'b1;

    // Single word latency
    @(posedge rclk); #1;
    write_word(8'hA5);
    @(posedge rclk); #1;
    check("single_valid_early", 32'(out_valid), 32'd0);
    check("single_rempty_low", 32'(rempty), 32'd0);
    @(posedge rclk); #1;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_rptr", 32'(rptr), 32'b00001);
    check("single_rempty", 32'(rempty), 32'd1);
    drain(10);
    out_ready = 1'b0;

    // Backpressure: only two words leave memory
    do_reset(2);
    @(posedge rclk); #1;
    for (int i = 0; i < 5; i++) write_word(8'h30 + 8'(i));
    repeat (6) @(posedge rclk);
    #1;
    check("bp_rptr", 32'(rptr), 32'b00011);
    check("bp_data", 32'(out_data), 32'h30);
    check("bp_rempty", 32'(rempty), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    drain(40);

    // Streaming across pointer wrap, one word per cycle
    do_reset(2);
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(posedge rclk); #1;
      if (c < 20) write_word(8'h80 + 8'(c));
      if (c >= 2 && c <= 21) check("stream_valid", 32'(out_valid), 32'd1);
      if (c == 17) check("stream_wrap_rptr", 32'(rptr), 32'b11000);
    end
    drain(10);

    // Random backpressure, 100 words
    do_reset(2);
    n_wr = 0;
    for (int c = 0; c < 3000 && n_wr < 100; c++) begin
      @(posedge rclk); #1;
      out_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() < 14 && $urandom_range(0, 1) == 1) begin
        write_word(8'($urandom));
        n_wr++;
      end
    end
    check("rand_all_written", 32'(n_wr), 32'd100);
    drain(300);

    // Reset while the output buffer is full
    do_reset(2);
    out_ready = 1'b0;
    @(posedge rclk); #1;
    for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
    repeat (5) @(posedge rclk);
    #1;
    check("mid_full_valid", 32'(out_valid), 32'd1);
    check("mid_full_rptr", 32'(rptr), 32'b00011);
    rrst_n = 1'b0;
    exp_q.delete();
    wbin = '0;
    rq2_wptr = '0;
    @(posedge rclk); #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rptr", 32'(rptr), 32'd0);
    rrst_n = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
